// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU memory-side blocks.
//   uword            : 32-bit data/address word.
//   widx_t           : 30-bit word index (byte address with the two LSBs dropped).
//   mem_resp_state_t : responder FSM states.
//   WORD_BYTES       : bytes per scratchpad word.
//   word_idx()       : byte address -> word index.
package hs_npu_pkg;

  typedef logic [31:0] uword;
  typedef logic [29:0] widx_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdFetch,
    StRdResp,
    StRdGap,
    StWrDrain,
    StHostRd
  } mem_resp_state_t;

  function automatic widx_t word_idx(input uword addr);
    return widx_t'(addr >> $clog2(WORD_BYTES));
  endfunction

endpackage

// File: rtl/hs_npu_scratchpad.sv
// Single-port scratchpad SRAM, DEPTH x 32 bits, no reset.
// Ports:
//   clk      : clock
//   we_i     : write enable (write wdata_i to addr_i at the clock edge)
//   addr_i   : word address
//   wdata_i  : write word
//   rdata_o  : registered read of addr_i, valid the cycle after addr_i is presented
module hs_npu_scratchpad
  import hs_npu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  uword          wdata_i,
  output uword          rdata_o
);

  uword mem [DEPTH];
  uword rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hs_npu_mem_responder.sv
// Memory-side responder for the NPU memory-ordering port. Serves NPU burst reads and
// writes from a single-port scratchpad; a host word port uses the SRAM when the NPU is idle.
// Ports:
//   clk, rst                            : clock, synchronous active-high reset
//   npu_read_ready_i / npu_valid_o      : read burst request / one-cycle response pulse
//   npu_write_valid_i / npu_ready_o     : write burst handshake
//   npu_invalidate_i                    : abort a pending read (no response)
//   npu_address_i, npu_wdata_i, npu_rdata_o : burst byte address and data
//   host_req_i, host_we_i, host_addr_i, host_wdata_i, host_ready_o : host word request
//   host_rvalid_o, host_rdata_o         : host read response (two cycles after accept)
//   err_o                               : sticky out-of-range access flag
//   rd_bursts_o, wr_bursts_o            : burst counters
// Build option: define HS_NPU_MEM_RESP_STATS_EN to build the burst counters; otherwise
// rd_bursts_o and wr_bursts_o are tied to 0.
module hs_npu_mem_responder
  import hs_npu_pkg::*;
#(
  parameter int unsigned BURST_SIZE = 2,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  npu_read_ready_i,
  output logic                  npu_valid_o,
  input  logic                  npu_write_valid_i,
  output logic                  npu_ready_o,
  input  logic                  npu_invalidate_i,
  input  uword                  npu_address_i,
  input  uword [BURST_SIZE-1:0] npu_wdata_i,
  output uword [BURST_SIZE-1:0] npu_rdata_o,
  input  logic                  host_we_i,
  input  logic                  host_req_i,
  input  uword                  host_addr_i,
  input  uword                  host_wdata_i,
  output logic                  host_ready_o,
  output logic                  host_rvalid_o,
  output uword                  host_rdata_o,
  output logic                  err_o,
  output uword                  rd_bursts_o,
  output uword                  wr_bursts_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BeatW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_SIZE - 1);

  mem_resp_state_t       state_q, state_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  widx_t                 base_q, base_d;
  uword [BURST_SIZE-1:0] wbuf_q, wbuf_d;
  uword [BURST_SIZE-1:0] rdata_q, rdata_d;
  uword                  host_rdata_q, host_rdata_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic                  err_q, err_d;
  logic                  rd_oob_q;

  widx_t sram_idx;
  logic  sram_we, access, oob;
  uword  sram_wdata, sram_rdata;
  widx_t npu_idx, host_idx;
  logic  wr_hs;

  assign npu_idx  = word_idx(npu_address_i);
  assign host_idx = word_idx(host_addr_i);

  // Out-of-range accesses never reach the SRAM; reads of them are zeroed at capture.
  assign oob   = sram_idx >= widx_t'(DEPTH);
  assign err_d = err_q | (access & oob);

  assign npu_valid_o  = !rst && (state_q == StRdResp) && !npu_invalidate_i;
  assign npu_ready_o  = !rst && (state_q == StIdle) && !npu_read_ready_i && !npu_invalidate_i;
  assign host_ready_o = !rst && (state_q == StIdle) && !npu_read_ready_i &&
                        !npu_write_valid_i && !npu_invalidate_i;
  assign wr_hs        = npu_write_valid_i && npu_ready_o;

  always_comb begin
    state_d       = state_q;
    beat_d        = '0;
    base_d        = base_q;
    wbuf_d        = wbuf_q;
    rdata_d       = rdata_q;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    sram_idx      = '0;
    sram_we       = 1'b0;
    sram_wdata    = '0;
    access        = 1'b0;
    case (state_q)
      StIdle: begin
        if (npu_invalidate_i) begin
          state_d = StIdle;
        end else if (npu_read_ready_i) begin
          // Word 0 is issued in the accept cycle so the whole burst is registered by RD_RESP.
          state_d  = StRdFetch;
          base_d   = npu_idx;
          sram_idx = npu_idx;
          access   = 1'b1;
        end else if (npu_write_valid_i) begin
          state_d = StWrDrain;
          base_d  = npu_idx;
          wbuf_d  = npu_wdata_i;
        end else if (host_req_i) begin
          sram_idx = host_idx;
          access   = 1'b1;
          if (host_we_i) begin
            sram_we    = 1'b1;
            sram_wdata = host_wdata_i;
          end else begin
            state_d = StHostRd;
          end
        end
      end
      StRdFetch: begin
        if (npu_invalidate_i) begin
          state_d = StIdle;
        end else begin
          rdata_d[beat_q] = rd_oob_q ? '0 : sram_rdata;
          if (beat_q == LastBeat) begin
            state_d = StRdResp;
          end else begin
            beat_d   = beat_q + 1'b1;
            sram_idx = base_q + widx_t'(beat_q) + widx_t'(1);
            access   = 1'b1;
          end
        end
      end
      StRdResp: state_d = npu_invalidate_i ? StIdle : StRdGap;
      StRdGap:  state_d = StIdle;
      StWrDrain: begin
        sram_idx   = base_q + widx_t'(beat_q);
        sram_we    = 1'b1;
        sram_wdata = wbuf_q[beat_q];
        access     = 1'b1;
        if (beat_q == LastBeat) begin
          state_d = StIdle;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StHostRd: begin
        host_rdata_d  = rd_oob_q ? '0 : sram_rdata;
        host_rvalid_d = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      base_q        <= '0;
      wbuf_q        <= '0;
      rdata_q       <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      err_q         <= 1'b0;
      rd_oob_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      wbuf_q        <= wbuf_d;
      rdata_q       <= rdata_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      err_q         <= err_d;
      rd_oob_q      <= oob;
    end
  end

  hs_npu_scratchpad #(
    .DEPTH (DEPTH)
  ) u_scratchpad (
    .clk     (clk),
    .we_i    (sram_we && !oob),
    .addr_i  (sram_idx[AW-1:0]),
    .wdata_i (sram_wdata),
    .rdata_o (sram_rdata)
  );

  assign npu_rdata_o   = rdata_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_rvalid_o = host_rvalid_q;
  assign err_o         = err_q;

`ifdef HS_NPU_MEM_RESP_STATS_EN
  uword rd_bursts_q, wr_bursts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bursts_q <= '0;
      wr_bursts_q <= '0;
    end else begin
      if (npu_valid_o) rd_bursts_q <= rd_bursts_q + 32'd1;
      if (wr_hs)       wr_bursts_q <= wr_bursts_q + 32'd1;
    end
  end

  assign rd_bursts_o = rd_bursts_q;
  assign wr_bursts_o = wr_bursts_q;
`else
  logic unused_wr_hs;
  assign unused_wr_hs = wr_hs;
  assign rd_bursts_o  = '0;
  assign wr_bursts_o  = '0;
`endif

endmodule

// File: tb/tb_hs_npu_mem_responder.sv
// Self-checking bench for hs_npu_mem_responder: a table of directed host/NPU transactions
// with hand-computed results, then hand-written sequences for invalidate, host starvation
// and reset during a write drain.
module tb_hs_npu_mem_responder;
  import hs_npu_pkg::*;

  localparam int unsigned BURST_SIZE = 2;
  localparam int unsigned DEPTH      = 1024;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  npu_read_ready = 1'b0;
  logic                  npu_valid;
  logic                  npu_write_valid = 1'b0;
  logic                  npu_ready;
  logic                  npu_invalidate = 1'b0;
  uword                  npu_address = '0;
  uword [BURST_SIZE-1:0] npu_wdata = '0;
  uword [BURST_SIZE-1:0] npu_rdata;
  logic                  host_we = 1'b0;
  logic                  host_req = 1'b0;
  uword                  host_addr = '0;
  uword                  host_wdata = '0;
  logic                  host_ready;
  logic                  host_rvalid;
  uword                  host_rdata;
  logic                  err;
  uword                  rd_bursts, wr_bursts;

  always #5 clk = ~clk;

  hs_npu_mem_responder #(
    .BURST_SIZE (BURST_SIZE),
    .DEPTH      (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .npu_read_ready_i  (npu_read_ready),
    .npu_valid_o       (npu_valid),
    .npu_write_valid_i (npu_write_valid),
    .npu_ready_o       (npu_ready),
    .npu_invalidate_i  (npu_invalidate),
    .npu_address_i     (npu_address),
    .npu_wdata_i       (npu_wdata),
    .npu_rdata_o       (npu_rdata),
    .host_we_i         (host_we),
    .host_req_i        (host_req),
    .host_addr_i       (host_addr),
    .host_wdata_i      (host_wdata),
    .host_ready_o      (host_ready),
    .host_rvalid_o     (host_rvalid),
    .host_rdata_o      (host_rdata),
    .err_o             (err),
    .rd_bursts_o       (rd_bursts),
    .wr_bursts_o       (wr_bursts)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef enum int {OpHostWr, OpHostRd, OpNpuWr, OpNpuRd} op_e;
  typedef struct {
    op_e  op;
    uword addr;
    uword d0;
    uword d1;
    uword e0;
    uword e1;
    logic e_err;
  } vec_t;

  function automatic vec_t mk(input op_e op, input uword addr, input uword d0, input uword d1,
                              input uword e0, input uword e1, input logic e_err);
    vec_t v;
    v.op = op; v.addr = addr; v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.e_err = e_err;
    return v;
  endfunction

  task automatic host_write(input uword addr, input uword data);
    int n = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = addr; host_wdata = data;
    @(negedge clk);
    while (!host_ready && n < 20) begin step(); n++; @(negedge clk); end
    if (!host_ready) chk("host_wr_ready_timeout", 32'(host_ready), 32'd1);
    step();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input uword addr, output uword data, output logic rv);
    int n = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = addr;
    @(negedge clk);
    while (!host_ready && n < 20) begin step(); n++; @(negedge clk); end
    if (!host_ready) chk("host_rd_ready_timeout", 32'(host_ready), 32'd1);
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    rv   = host_rvalid;
    data = host_rdata;
    step();
  endtask

  // Returns the number of cycles npu_ready_o stays low after the handshake.
  task automatic npu_write(input uword addr, input uword d0, input uword d1, output int low);
    npu_write_valid = 1'b1; npu_address = addr; npu_wdata[0] = d0; npu_wdata[1] = d1;
    @(negedge clk);
    chk("wr_ready_idle", 32'(npu_ready), 32'd1);
    step();
    npu_write_valid = 1'b0;
    low = 0;
    @(negedge clk);
    while (!npu_ready && low < 20) begin low++; step(); @(negedge clk); end
    step();
  endtask

  // lat: cycles from the accept cycle to npu_valid_o. gap_ok: the cycle after the pulse has
  // valid and ready low (RD_GAP). idle_ok: the cycle after that is IDLE again.
  task automatic npu_read(input uword addr, output uword r0, output uword r1, output int lat,
                          output logic gap_ok, output logic idle_ok);
    npu_read_ready = 1'b1; npu_address = addr;
    @(negedge clk);
    chk("rd_masks_wr_ready", 32'(npu_ready), 32'd0);
    step();
    npu_read_ready = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!npu_valid && lat < 20) begin step(); lat++; @(negedge clk); end
    r0 = npu_rdata[0];
    r1 = npu_rdata[1];
    step();
    @(negedge clk);
    gap_ok = !npu_valid && !npu_ready;
    step();
    @(negedge clk);
    idle_ok = npu_ready;
    step();
  endtask

  vec_t vecs[$];

  initial begin
    uword r0, r1;
    int   lat, low, seen, viol, pulses;
    logic gap_ok, idle_ok, rv;

    vecs.push_back(mk(OpHostWr, 32'h040, 32'h11111111, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OpHostWr, 32'h044, 32'h22222222, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OpNpuRd,  32'h040, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 1'b0));
    vecs.push_back(mk(OpNpuWr,  32'h100, 32'hDEADBEEF, 32'h0000CAFE, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OpHostRd, 32'h104, 32'h0, 32'h0, 32'h0000CAFE, 32'h0, 1'b0));
    vecs.push_back(mk(OpHostRd, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0));
    vecs.push_back(mk(OpNpuRd,  32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0000CAFE, 1'b0));
    vecs.push_back(mk(OpNpuRd,  32'h043, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 1'b0));
    vecs.push_back(mk(OpNpuWr,  32'h200, 32'h13579BDF, 32'h2468ACE0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OpNpuRd,  32'h202, 32'h0, 32'h0, 32'h13579BDF, 32'h2468ACE0, 1'b0));
    vecs.push_back(mk(OpHostWr, 32'hFFC, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OpHostRd, 32'hFFC, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0));
    vecs.push_back(mk(OpHostWr, 32'h000, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 1'b0));
    // Burst straddling the top of the scratchpad: word 1 is out of range.
    vecs.push_back(mk(OpNpuRd,  32'hFFC, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b1));
    vecs.push_back(mk(OpNpuRd,  32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(OpNpuWr,  32'h1000, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(OpHostRd, 32'h000, 32'h0, 32'h0, 32'h0BADF00D, 32'h0, 1'b1));
    vecs.push_back(mk(OpHostWr, 32'h1004, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(OpHostRd, 32'h1004, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1));

    // Reset state.
    step(); step(); step();
    @(negedge clk);
    chk("rst_npu_valid", 32'(npu_valid), 32'd0);
    chk("rst_npu_ready", 32'(npu_ready), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata0", npu_rdata[0], 32'd0);
    chk("rst_rdata1", npu_rdata[1], 32'd0);
    chk("rst_host_rdata", host_rdata, 32'd0);
    chk("rst_rd_bursts", rd_bursts, 32'd0);
    chk("rst_wr_bursts", wr_bursts, 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OpHostWr: host_write(vecs[i].addr, vecs[i].d0);
        OpHostRd: begin
          host_read(vecs[i].addr, r0, rv);
          chk($sformatf("v%0d_host_rvalid", i), 32'(rv), 32'd1);
          chk($sformatf("v%0d_host_rdata", i), r0, vecs[i].e0);
        end
        OpNpuWr: begin
          npu_write(vecs[i].addr, vecs[i].d0, vecs[i].d1, low);
          exp_wr++;
          chk($sformatf("v%0d_wr_busy_cycles", i), 32'(low), 32'(BURST_SIZE));
        end
        default: begin
          npu_read(vecs[i].addr, r0, r1, lat, gap_ok, idle_ok);
          exp_rd++;
          chk($sformatf("v%0d_rd_latency", i), 32'(lat), 32'(BURST_SIZE + 1));
          chk($sformatf("v%0d_rdata0", i), r0, vecs[i].e0);
          chk($sformatf("v%0d_rdata1", i), r1, vecs[i].e1);
          chk($sformatf("v%0d_rd_gap", i), 32'(gap_ok), 32'd1);
          chk($sformatf("v%0d_rd_idle_after_gap", i), 32'(idle_ok), 32'd1);
        end
      endcase
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
    end

    // Invalidate during RD_FETCH: no response, back in IDLE next cycle.
    npu_address = 32'h040; npu_read_ready = 1'b1;
    step();
    npu_read_ready = 1'b0; npu_invalidate = 1'b1;
    @(negedge clk);
    chk("inv_fetch_no_valid", 32'(npu_valid), 32'd0);
    step();
    npu_invalidate = 1'b0;
    @(negedge clk);
    chk("inv_fetch_idle", 32'(npu_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (npu_valid) seen++;
      step();
    end
    chk("inv_fetch_no_late_valid", 32'(seen), 32'd0);
    npu_read(32'h040, r0, r1, lat, gap_ok, idle_ok);
    exp_rd++;
    chk("after_inv_latency", 32'(lat), 32'(BURST_SIZE + 1));
    chk("after_inv_rdata0", r0, 32'h11111111);
    chk("after_inv_rdata1", r1, 32'h22222222);

    // Invalidate coincident with RD_RESP suppresses the pulse and skips RD_GAP.
    npu_address = 32'h040; npu_read_ready = 1'b1;
    step();
    npu_read_ready = 1'b0;
    step(); step();
    npu_invalidate = 1'b1;
    @(negedge clk);
    chk("inv_resp_suppressed", 32'(npu_valid), 32'd0);
    step();
    npu_invalidate = 1'b0;
    @(negedge clk);
    chk("inv_resp_idle", 32'(npu_ready), 32'd1);
    step();

    // Continuous reads starve the host; dropping read_ready in IDLE lets it in.
    npu_address = 32'h040; npu_read_ready = 1'b1;
    host_addr = 32'h040; host_we = 1'b0; host_req = 1'b1;
    viol = 0; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (host_ready) viol++;
      if (npu_valid) pulses++;
      step();
    end
    exp_rd += 4;
    chk("starve_host_ready_seen", 32'(viol), 32'd0);
    chk("starve_read_pulses", 32'(pulses), 32'd4);
    npu_read_ready = 1'b0;
    @(negedge clk);
    chk("starve_host_accept", 32'(host_ready), 32'd1);
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    chk("starve_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("starve_host_rdata", host_rdata, 32'h11111111);
    step();

`ifdef HS_NPU_MEM_RESP_STATS_EN
    chk("cnt_rd_bursts", rd_bursts, 32'(exp_rd));
    chk("cnt_wr_bursts", wr_bursts, 32'(exp_wr));
`else
    chk("cnt_rd_bursts_tied", rd_bursts, 32'd0);
    chk("cnt_wr_bursts_tied", wr_bursts, 32'd0);
`endif

    // Reset in the first WR_DRAIN cycle: word 0 still lands, everything else clears.
    npu_write_valid = 1'b1; npu_address = 32'h300;
    npu_wdata[0] = 32'h77777777; npu_wdata[1] = 32'h88888888;
    step();
    npu_write_valid = 1'b0; rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_npu_valid", 32'(npu_valid), 32'd0);
    chk("mid_rst_npu_ready", 32'(npu_ready), 32'd0);
    chk("mid_rst_host_ready", 32'(host_ready), 32'd0);
    chk("mid_rst_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_rdata0", npu_rdata[0], 32'd0);
    chk("mid_rst_rdata1", npu_rdata[1], 32'd0);
    chk("mid_rst_host_rdata", host_rdata, 32'd0);
    chk("mid_rst_rd_bursts", rd_bursts, 32'd0);
    chk("mid_rst_wr_bursts", wr_bursts, 32'd0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_idle_ready", 32'(npu_ready), 32'd1);
    step();
    host_read(32'h300, r0, rv);
    chk("post_rst_partial_rvalid", 32'(rv), 32'd1);
    chk("post_rst_partial_word", r0, 32'h77777777);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
